line_sensor_frontend: RTL and testbench

Sensor-side counterpart of the drive state machine. It turns the raw IR line sensors and the bumper switch into the clean, mutually consistent steering requests that the motor/H-bridge controller consumes: veerLeft, veerRight, junction, lineLost and collision. The block synchronises, samples and debounces the raw inputs, classifies line position with a small state machine, and latches bumper hits until software clears them.

---
 rtl/line_sensor_frontend_pkg.sv | 49 ++++
 rtl/line_sensor_frontend_debouncer.sv | 49 ++++
 rtl/line_sensor_frontend.sv | 138 +++++++++++++
 tb/tb_line_sensor_frontend.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_sensor_frontend_pkg.sv
// Shared definitions for the line sensor front end and the drive controller.
package line_sensor_frontend_pkg;

   // Defaults shared with the drive controller so both agree on timing.
   localparam int DEF_SAMPLE_DIV       = 5000;  // 100 us at 50 MHz
   localparam int DEF_DEBOUNCE_SAMPLES = 8;
   localparam int DEF_LOST_SAMPLES     = 20;

   // Bit positions inside the 3-bit sensor vector.
   localparam int SENSOR_LEFT   = 2;
   localparam int SENSOR_CENTRE = 1;
   localparam int SENSOR_RIGHT  = 0;

   // Position of the bumper among the debounced inputs (after the sensors).
   localparam int BUMPER_IDX = 3;
   localparam int NUM_INPUTS = 4;

   // Classifier state encoding.
   typedef enum logic [2:0] {
      CENTERED = 3'd0,
      VEER_L   = 3'd1,
      VEER_R   = 3'd2,
      JUNCTION = 3'd3,
      LOST     = 3'd4
   } line_state_t;

   // Steering request bundle handed to the motor controller.
   typedef struct packed {
      logic veer_left;
      logic veer_right;
      logic junction;
      logic line_lost;
   } steer_t;

   // One-hot steering request for a classifier state; CENTERED requests nothing.
   function automatic steer_t decode_state(input line_state_t s);
      steer_t r;
      r = '0;
      case (s)
         VEER_L:   r.veer_left  = 1'b1;
         VEER_R:   r.veer_right = 1'b1;
         JUNCTION: r.junction   = 1'b1;
         LOST:     r.line_lost  = 1'b1;
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/line_sensor_frontend_debouncer.sv
// One-bit input conditioner: 2-flop synchroniser followed by a sample-tick
// driven debounce counter. A new level is accepted only after
// DEBOUNCE_SAMPLES consecutive ticks that disagree with the stable value.
module input_debouncer
   import line_sensor_frontend_pkg::*;
#(
   parameter int   DEBOUNCE_SAMPLES = DEF_DEBOUNCE_SAMPLES,
   parameter logic RESET_VAL        = 1'b0
) (
   input  logic clock,
   input  logic resetN,
   input  logic raw,
   input  logic sample_tick,
   output logic stable
);

   localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
   localparam logic [CW-1:0] ACCEPT_AT = CW'(DEBOUNCE_SAMPLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          synced;

   assign synced = sync[1];

   // Two-flop synchroniser; reset to the idle level so no spurious edge appears.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) sync <= {2{RESET_VAL}};
      else         sync <= {sync[0], raw};
   end

   // Debounce: any agreeing sample restarts the run, the Nth disagreeing one flips.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         stable <= RESET_VAL;
         cnt    <= '0;
      end else if (sample_tick) begin
         if (synced == stable) begin
            cnt <= '0;
         end else if (cnt == ACCEPT_AT) begin
            stable <= synced;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/line_sensor_frontend.sv
// Line sensor front end: conditions the IR line sensors and bumper, classifies
// the line position and latches bumper hits for the motor controller.
module line_sensor_frontend
   import line_sensor_frontend_pkg::*;
#(
   parameter int SAMPLE_DIV       = DEF_SAMPLE_DIV,
   parameter int DEBOUNCE_SAMPLES = DEF_DEBOUNCE_SAMPLES,
   parameter int LOST_SAMPLES     = DEF_LOST_SAMPLES
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic [2:0] lineSensor,
   input  logic       bumperN,
   input  logic       collisionClear,
   output logic       veerLeft,
   output logic       veerRight,
   output logic       junction,
   output logic       lineLost,
   output logic       collision,
   output logic       sampleTick
);

   localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [PW-1:0] TICK_AT = PW'(SAMPLE_DIV - 1);
   localparam int LW = $clog2(LOST_SAMPLES + 1);
   localparam logic [LW-1:0] LOST_AT = LW'(LOST_SAMPLES);

   logic [PW-1:0]         pre_cnt;
   logic                  eval_tick;
   logic [NUM_INPUTS-1:0] raw_in;
   logic [NUM_INPUTS-1:0] deb;
   logic [2:0]            pattern;
   logic                  bump_pressed;
   line_state_t           state, state_nxt;
   logic [LW-1:0]         lost_cnt, lost_nxt;
   steer_t                steer_q;
   logic                  collision_q;

   // Prescaler: free-running 0..SAMPLE_DIV-1, tick on the last count.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN)                pre_cnt <= '0;
      else if (pre_cnt == TICK_AT) pre_cnt <= '0;
      else                        pre_cnt <= pre_cnt + PW'(1);
   end

   assign sampleTick = (pre_cnt == TICK_AT);

   // Classifier runs one cycle after the tick, once the debouncers have updated.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) eval_tick <= 1'b0;
      else         eval_tick <= sampleTick;
   end

   // Sensors in their own bit positions, bumper on top.
   assign raw_in = {bumperN, lineSensor};

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_deb
      // Bumper idles released (high); line sensors idle dark (low).
      input_debouncer #(
         .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
         .RESET_VAL        (i == BUMPER_IDX)
      ) u_deb (
         .clock       (clock),
         .resetN      (resetN),
         .raw         (raw_in[i]),
         .sample_tick (sampleTick),
         .stable      (deb[i])
      );
   end

   assign pattern      = {deb[SENSOR_LEFT], deb[SENSOR_CENTRE], deb[SENSOR_RIGHT]};
   assign bump_pressed = ~deb[BUMPER_IDX];

   // Classifier state and lost-line run counter.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state    <= CENTERED;
         lost_cnt <= '0;
      end else begin
         state    <= state_nxt;
         lost_cnt <= lost_nxt;
      end
   end

   // Next-state: 101 is physically impossible and just holds; 000 holds until
   // the dark run is long enough to call the line lost.
   always_comb begin
      state_nxt = state;
      lost_nxt  = lost_cnt;
      if (eval_tick) begin
         case (pattern)
            3'b010: begin
               state_nxt = CENTERED;
               lost_nxt  = '0;
            end
            3'b110, 3'b100: begin
               state_nxt = VEER_L;
               lost_nxt  = '0;
            end
            3'b011, 3'b001: begin
               state_nxt = VEER_R;
               lost_nxt  = '0;
            end
            3'b111: begin
               state_nxt = JUNCTION;
               lost_nxt  = '0;
            end
            3'b000: begin
               if (lost_cnt != LOST_AT) lost_nxt = lost_cnt + LW'(1);
               if (lost_nxt == LOST_AT) state_nxt = LOST;
            end
            default: begin
               lost_nxt = '0;
            end
         endcase
      end
   end

   // Output register keeps the steering requests glitch-free and one-hot.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) steer_q <= '0;
      else         steer_q <= decode_state(state);
   end

   // Collision latch: a pressed bumper always wins over a clear request.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN)             collision_q <= 1'b0;
      else if (bump_pressed)   collision_q <= 1'b1;
      else if (collisionClear) collision_q <= 1'b0;
   end

   assign veerLeft  = steer_q.veer_left;
   assign veerRight = steer_q.veer_right;
   assign junction  = steer_q.junction;
   assign lineLost  = steer_q.line_lost;
   assign collision = collision_q;

endmodule

// File: tb/tb_line_sensor_frontend.sv
// Self-checking bench for line_sensor_frontend (SAMPLE_DIV=4, DEBOUNCE=3, LOST=5).
module tb_line_sensor_frontend;

   localparam int DIV  = 4;
   localparam int DEB  = 3;
   localparam int LOST = 5;

   logic       clock = 1'b0;
   logic       resetN = 1'b1;
   logic [2:0] lineSensor = 3'b010;
   logic       bumperN = 1'b1;
   logic       collisionClear = 1'b0;
   logic       veerLeft, veerRight, junction, lineLost, collision, sampleTick;
   logic [4:0] ovec;

   typedef struct {
      logic [4:0] vec;
      int         due;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc;

   line_sensor_frontend #(
      .SAMPLE_DIV       (DIV),
      .DEBOUNCE_SAMPLES (DEB),
      .LOST_SAMPLES     (LOST)
   ) dut (
      .clock          (clock),
      .resetN         (resetN),
      .lineSensor     (lineSensor),
      .bumperN        (bumperN),
      .collisionClear (collisionClear),
      .veerLeft       (veerLeft),
      .veerRight      (veerRight),
      .junction       (junction),
      .lineLost       (lineLost),
      .collision      (collision),
      .sampleTick     (sampleTick)
   );

   always #5 clock = ~clock;

   assign ovec = {veerLeft, veerRight, junction, lineLost, collision};

   // Clock edges since reset release; edge n ends cycle n.
   always @(posedge clock or negedge resetN) begin
      if (!resetN) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   // Edge on which a level applied after edge e0 becomes debounced:
   // two sync edges, then DEB consecutive tick edges (multiples of DIV).
   function automatic int deb_edge(input int e0);
      int t1;
      t1 = e0 + 3;
      while (t1 % DIV != 0) t1++;
      return t1 + (DEB - 1) * DIV;
   endfunction

   // Pop the next expectation and wait for the outputs to move.
   task automatic wait_out(input int budget, input string name);
      exp_t       e;
      logic [4:0] prev, cur;
      int         when;
      bit         seen;
      e = exp_q.pop_front();
      prev = ovec;
      cur = prev;
      seen = 0;
      when = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clock);
         cur = ovec;
         if (cur !== prev) begin
            seen = 1;
            when = cyc;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL %s: no output change in %0d cycles, outputs %b, want %b", name, budget, cur, e.vec);
      end else begin
         if (cur !== e.vec) begin
            n_bad++;
            $display("FAIL %s: outputs %b, want %b", name, cur, e.vec);
         end
         n_cmp++;
         if (when != e.due) begin
            n_bad++;
            $display("FAIL %s_latency: changed at cycle %0d, want %0d", name, when, e.due);
         end
      end
   endtask

   task automatic tick_run(input int n, input string name);
      logic [5:0] want;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         want = {(cyc % DIV == DIV - 1), 5'b00000};
         n_cmp++;
         if ({sampleTick, ovec} !== want) begin
            n_bad++;
            $display("FAIL %s cyc %0d: tick+outputs %b, want %b", name, cyc, {sampleTick, ovec}, want);
         end
      end
   endtask

   task automatic hold(input int n, input logic [4:0] want, input string name);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         n_cmp++;
         if (ovec !== want) begin
            n_bad++;
            $display("FAIL %s cyc %0d: outputs %b, want %b", name, cyc, ovec, want);
         end
      end
   endtask

   task automatic test_reset();
      #1 resetN = 1'b0;
      lineSensor = 3'b010;
      bumperN = 1'b1;
      collisionClear = 1'b0;
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({sampleTick, ovec} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_state: tick+outputs %b, want 000000", {sampleTick, ovec});
      end
      resetN = 1'b1;
      tick_run(40, "reset_tick");
   endtask

   task automatic test_glitch();
      lineSensor = 3'b011;
      hold(2 * DIV, 5'b00000, "glitch_a");
      lineSensor = 3'b010;
      hold(2 * DIV, 5'b00000, "glitch_gap");
      lineSensor = 3'b011;
      hold(2 * DIV, 5'b00000, "glitch_b");
      lineSensor = 3'b010;
      hold(24, 5'b00000, "glitch_after");
   endtask

   task automatic test_veer();
      int e0;
      e0 = cyc;
      lineSensor = 3'b110;
      exp_q.push_back('{5'b10000, deb_edge(e0) + 2});
      wait_out(2 + 4 * DIV + 2, "veer_left");
      hold(6, 5'b10000, "veer_left_hold");
      e0 = cyc;
      lineSensor = 3'b011;
      exp_q.push_back('{5'b01000, deb_edge(e0) + 2});
      wait_out(2 + 4 * DIV + 2, "veer_right");
   endtask

   task automatic test_lost_junction();
      int e0;
      e0 = cyc;
      lineSensor = 3'b000;
      exp_q.push_back('{5'b00010, deb_edge(e0) + 2 + (LOST - 1) * DIV});
      wait_out(80, "line_lost");
      hold(3 * DIV, 5'b00010, "lost_hold");
      e0 = cyc;
      lineSensor = 3'b111;
      exp_q.push_back('{5'b00100, deb_edge(e0) + 2});
      wait_out(40, "junction");
   endtask

   task automatic test_collision();
      int e0, t3r;
      e0 = cyc;
      bumperN = 1'b0;
      exp_q.push_back('{5'b00101, deb_edge(e0) + 1});
      wait_out(40, "collision_set");
      collisionClear = 1'b1;
      @(negedge clock);
      collisionClear = 1'b0;
      n_cmp++;
      if (ovec !== 5'b00101) begin
         n_bad++;
         $display("FAIL clear_while_pressed: outputs %b, want 00101", ovec);
      end
      hold(4, 5'b00101, "collision_hold");
      e0 = cyc;
      bumperN = 1'b1;
      t3r = deb_edge(e0);
      while (cyc < t3r) @(negedge clock);
      hold(1, 5'b00101, "release_keeps_latch");
      collisionClear = 1'b1;
      @(negedge clock);
      collisionClear = 1'b0;
      n_cmp++;
      if (ovec !== 5'b00100) begin
         n_bad++;
         $display("FAIL collision_clear: outputs %b, want 00100", ovec);
      end
      collisionClear = 1'b1;
      @(negedge clock);
      collisionClear = 1'b0;
      hold(4, 5'b00100, "clear_when_idle");
   endtask

   task automatic test_reset_mid();
      lineSensor = 3'b110;
      bumperN = 1'b0;
      repeat (30) @(negedge clock);
      n_cmp++;
      if (ovec !== 5'b10001) begin
         n_bad++;
         $display("FAIL pre_reset: outputs %b, want 10001", ovec);
      end
      @(posedge clock);
      #2 resetN = 1'b0;
      #1;
      n_cmp++;
      if ({sampleTick, ovec} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_async: tick+outputs %b, want 000000", {sampleTick, ovec});
      end
      bumperN = 1'b1;
      lineSensor = 3'b010;
      @(negedge clock);
      resetN = 1'b1;
      tick_run(40, "rerun_tick");
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_veer();
      test_lost_junction();
      test_collision();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
